// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the LSU data port and dmem_ctrl.
// The master drives requests; the slave returns data and status.
interface dmem_ctrl_if #(
    parameter int ADDR_WIDTH = 14
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_byte_en;
    logic                  mem_wr;
    logic                  mem_rd;
    logic [31:0]           mem_rdata;
    logic                  mem_vld;
    logic                  mem_busy;
    logic                  mem_overrun;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_byte_en,
        output mem_wr,
        output mem_rd,
        input  mem_rdata,
        input  mem_vld,
        input  mem_busy,
        input  mem_overrun
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_byte_en,
        input  mem_wr,
        input  mem_rd,
        output mem_rdata,
        output mem_vld,
        output mem_busy,
        output mem_overrun
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word SRAM behind the LSU port with
// programmable wait states and a one-cycle response pulse.
module dmem_ctrl #(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rstn,
    dmem_ctrl_if.slave mem
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] CNT_LD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        wr_q;
    logic [31:0] rdata_q;
    logic [31:0] arr_word;
    logic        req;
    logic        accept;
    logic        unused_addr_lsb;

    logic [31:0] mem_q [DEPTH];

    assign req             = mem.mem_rd | mem.mem_wr;
    assign unused_addr_lsb = ^mem.mem_addr[1:0];
    assign arr_word        = mem_q[idx_q];

    // Next-state and acceptance decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                accept = req;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                accept  = req;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (accept) begin
            state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            cnt_d   = CNT_LD;
        end
    end

    // State and wait counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the request on acceptance; rd+wr together acts as a write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            idx_q   <= mem.mem_addr[ADDR_WIDTH-1:2];
            wdata_q <= mem.mem_wdata;
            be_q    <= mem.mem_byte_en;
            wr_q    <= mem.mem_wr;
        end
    end

    // Hold the last response word so rdata is stable outside RESP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (state_q == S_RESP) begin
            rdata_q <= arr_word;
        end
    end

    // Array write commits at the end of RESP, merging enabled lanes only.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // RESP returns the pre-write word, giving read-before-write.
    assign mem.mem_rdata   = (state_q == S_RESP) ? arr_word : rdata_q;
    assign mem.mem_vld     = (state_q == S_RESP);
    assign mem.mem_busy    = (state_q == S_WAIT);
    assign mem.mem_overrun = (state_q == S_WAIT) & req;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: three instances with 2, 0 and 3
// wait states share one stimulus bus gated by a select.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    int          sel;

    always #5 clk = ~clk;

    dmem_ctrl_if #(.ADDR_WIDTH(14)) if0 ();
    dmem_ctrl_if #(.ADDR_WIDTH(14)) if1 ();
    dmem_ctrl_if #(.ADDR_WIDTH(14)) if2 ();

    dmem_ctrl #(.ADDR_WIDTH(14), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rstn(rstn), .mem(if0.slave));
    dmem_ctrl #(.ADDR_WIDTH(14), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rstn(rstn), .mem(if1.slave));
    dmem_ctrl #(.ADDR_WIDTH(14), .WAIT_CYCLES(3)) u2 (
        .clk(clk), .rstn(rstn), .mem(if2.slave));

    assign if0.mem_addr    = addr;
    assign if0.mem_wdata   = wdata;
    assign if0.mem_byte_en = be;
    assign if0.mem_rd      = rd & (sel == 0);
    assign if0.mem_wr      = wr & (sel == 0);
    assign if1.mem_addr    = addr;
    assign if1.mem_wdata   = wdata;
    assign if1.mem_byte_en = be;
    assign if1.mem_rd      = rd & (sel == 1);
    assign if1.mem_wr      = wr & (sel == 1);
    assign if2.mem_addr    = addr;
    assign if2.mem_wdata   = wdata;
    assign if2.mem_byte_en = be;
    assign if2.mem_rd      = rd & (sel == 2);
    assign if2.mem_wr      = wr & (sel == 2);

    logic        vld_m, busy_m, ovr_m;
    logic [31:0] rdata_m;

    always_comb begin
        vld_m   = if0.mem_vld;
        rdata_m = if0.mem_rdata;
        busy_m  = if0.mem_busy;
        ovr_m   = if0.mem_overrun;
        if (sel == 1) begin
            vld_m   = if1.mem_vld;
            rdata_m = if1.mem_rdata;
            busy_m  = if1.mem_busy;
            ovr_m   = if1.mem_overrun;
        end else if (sel == 2) begin
            vld_m   = if2.mem_vld;
            rdata_m = if2.mem_rdata;
            busy_m  = if2.mem_busy;
            ovr_m   = if2.mem_overrun;
        end
    end

    typedef struct {
        logic [31:0] data;
        bit          chk;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ovr_cnt = 0;
    bit   busy1_seen = 1'b0;

    function automatic int wait_of(int s);
        return (s == 0) ? 2 : (s == 1) ? 0 : 3;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pop and compare on every response pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (sel == 1 && busy_m) busy1_seen = 1'b1;
                if (ovr_m) ovr_cnt++;
                if ((if0.mem_vld && sel != 0) ||
                    (if1.mem_vld && sel != 1) ||
                    (if2.mem_vld && sel != 2)) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stray_vld cyc=%0d sel=%0d", cyc, sel);
                end
                if (vld_m) begin
                    n_chk++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_vld cyc=%0d sel=%0d data=%h",
                                 cyc, sel, rdata_m);
                    end else begin
                        e = sb.pop_front();
                        if (e.cyc != cyc || (e.chk && rdata_m !== e.data)) begin
                            n_fail++;
                            $display("FAIL resp sel=%0d got data=%h cyc=%0d, want data=%h cyc=%0d",
                                     sel, rdata_m, cyc, e.data, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [13:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic r, input logic w,
                         input bit push, input bit chk,
                         input logic [31:0] exp);
        @(posedge clk);
        #1;
        addr  = a;
        wdata = d;
        be    = b;
        rd    = r;
        wr    = w;
        if (push) sb.push_back('{data: exp, chk: chk, cyc: cyc + 1 + wait_of(sel)});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        idle();
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            #7;
            if (sb.size() == 0) done = 1'b1;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rstn  = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        rd    = 1'b0;
        wr    = 1'b0;
        sel   = 0;
        #12;
        check("rst_rdata0", if0.mem_rdata, 32'h0);
        check("rst_rdata1", if1.mem_rdata, 32'h0);
        check("rst_rdata2", if2.mem_rdata, 32'h0);
        check("rst_flags", {29'd0,
              if0.mem_vld | if1.mem_vld | if2.mem_vld,
              if0.mem_busy | if1.mem_busy | if2.mem_busy,
              if0.mem_overrun | if1.mem_overrun | if2.mem_overrun}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Two wait states: basic write/read latency.
        issue(14'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1, 0, 32'h0);
        drain();
        issue(14'h0010, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1, 32'hDEADBEEF);
        drain();
        check("rdata_hold", rdata_m, 32'hDEADBEEF);

        // Byte merge, each request issued in the previous RESP cycle.
        issue(14'h0020, 32'h11223344, 4'hF, 1'b0, 1'b1, 1, 0, 32'h0);
        idle();
        idle();
        issue(14'h0020, 32'hAABBCCDD, 4'h5, 1'b0, 1'b1, 1, 1, 32'h11223344);
        idle();
        idle();
        issue(14'h0020, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1, 32'h11BB33DD);
        drain();
        issue(14'h0020, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 1, 1, 32'h11BB33DD);
        drain();
        issue(14'h0020, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1, 32'h11BB33DD);
        drain();

        // Zero wait states: alternating write/read every cycle.
        sel = 1;
        busy1_seen = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            issue(14'h0040, 32'(k), 4'hF, 1'b0, 1'b1, 1, (k > 1),
                  32'(k - 1));
            issue(14'h0040, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1, 32'(k));
        end
        drain();
        check("busy_w0", {31'd0, busy1_seen}, 32'h0);

        // Simultaneous rd+wr returns the old word.
        issue(14'h0080, 32'h12345678, 4'hF, 1'b0, 1'b1, 1, 0, 32'h0);
        issue(14'h0080, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1, 1, 1, 32'h12345678);
        issue(14'h0080, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1, 32'hCAFEF00D);
        drain();

        // Three wait states: dropped requests raise overrun only.
        sel = 2;
        issue(14'h0100, 32'h0BADF00D, 4'hF, 1'b0, 1'b1, 1, 0, 32'h0);
        drain();
        ovr_cnt = 0;
        issue(14'h0100, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1, 32'h0BADF00D);
        issue(14'h0104, 32'h0, 4'h0, 1'b1, 1'b0, 0, 0, 32'h0);
        drain();
        check("ovr_once", 32'(ovr_cnt), 32'd1);
        issue(14'h0100, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1, 32'h0BADF00D);
        idle();
        issue(14'h0100, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 0, 0, 32'h0);
        drain();
        check("ovr_twice", 32'(ovr_cnt), 32'd2);
        issue(14'h0100, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1, 32'h0BADF00D);
        drain();

        // Reset during the wait of a write abandons it.
        sel = 0;
        issue(14'h0090, 32'h13579BDF, 4'hF, 1'b0, 1'b1, 1, 0, 32'h0);
        drain();
        issue(14'h0090, 32'h2468ACE0, 4'hF, 1'b0, 1'b1, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        rd   = 1'b0;
        wr   = 1'b0;
        rstn = 1'b0;
        #3;
        check("midrst_rdata", rdata_m, 32'h0);
        check("midrst_flags", {29'd0, vld_m, busy_m, ovr_m}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        issue(14'h0090, 32'h0, 4'h0, 1'b1, 1'b0, 1, 1, 32'h13579BDF);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
